// File: rtl/md_alu_sequencer_if.sv
// Request/response and shared-ALU signal bundle for md_alu_sequencer.
// "slave" is the sequencer's view; "master" is the view of the pipeline
// logic that issues operations, grants the ALU and returns its result.
interface md_alu_sequencer_if #(
  parameter int Width = 32
);
  // Pipeline control
  logic             flush_i;
  logic             busy_o;

  // Operation request
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [Width-1:0] req_a_i;
  logic [Width-1:0] req_b_i;

  // Result
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [Width-1:0] resp_data_o;

  // Shared ALU port
  logic             alu_req_o;
  logic             alu_gnt_i;
  logic [Width-1:0] alu_a_o;
  logic [Width-1:0] alu_b_o;
  logic [3:0]       alu_sel_o;
  logic [Width-1:0] alu_res_i;

  modport slave (
    input  flush_i, req_valid_i, req_op_i, req_a_i, req_b_i,
           resp_ready_i, alu_gnt_i, alu_res_i,
    output busy_o, req_ready_o, resp_valid_o, resp_data_o,
           alu_req_o, alu_a_o, alu_b_o, alu_sel_o
  );

  modport master (
    output flush_i, req_valid_i, req_op_i, req_a_i, req_b_i,
           resp_ready_i, alu_gnt_i, alu_res_i,
    input  busy_o, req_ready_o, resp_valid_o, resp_data_o,
           alu_req_o, alu_a_o, alu_b_o, alu_sel_o
  );
endinterface

// File: rtl/md_alu_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer. One add/sub per step is
// borrowed from the shared pipeline ALU; a step only commits when granted.
// Shift/iteration state lives here: hi_q is the accumulator (multiply) or
// partial remainder (divide); lo_q is the multiplier (multiply) or quotient
// (divide). a_q doubles as multiplicand, b_q as divisor.
// Optional build macro: MD_EARLY_OUT_EN -- CHECK finishes trivial operands
// (zero multiply operand, dividend < divisor) without iterating.
module md_alu_sequencer #(
  parameter int Width = 32,
  parameter int CntW  = $clog2(Width)
) (
  input logic clk_i,
  input logic rst_i,
  md_alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] SelAdd = 4'b0000;
  localparam logic [3:0] SelSub = 4'b0001;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;
  logic [Width-1:0] hi_q, hi_d;
  logic [Width-1:0] lo_q, lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Opcode bit 1 selects divide; bit 0 selects the high half (MULHU) or
  // the remainder (REMU), both of which live in hi_q at the end.
  logic             is_div;
  logic             sel_hi;
  logic [Width-1:0] rs;
  logic             rem_top;
  logic             take;
  logic             carry;
  logic [Width-1:0] addend;

  assign is_div = op_q[1];
  assign sel_hi = op_q[0];

  // Per-step datapath terms derived from held state and the ALU result.
  always_comb begin
    rs      = {hi_q[Width-2:0], lo_q[Width-1]};
    rem_top = hi_q[Width-1];
    take    = rem_top | (rs >= b_q);
    carry   = (bus.alu_res_i < hi_q);
    addend  = lo_q[0] ? a_q : '0;
  end

  // Next-state, datapath update and all outputs.
  always_comb begin
    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block leaves a signal unassigned (no latches).
    state_d          = state_q;
    op_d             = op_q;
    a_d              = a_q;
    b_d              = b_q;
    hi_d             = hi_q;
    lo_d             = lo_q;
    cnt_d            = cnt_q;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.resp_data_o  = '0;
    bus.busy_o       = (state_q != S_IDLE);
    bus.alu_req_o    = 1'b0;
    bus.alu_a_o      = '0;
    bus.alu_b_o      = '0;
    bus.alu_sel_o    = SelAdd;

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          op_d    = bus.req_op_i;
          a_d     = bus.req_a_i;
          b_d     = bus.req_b_i;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (is_div && (b_q == '0)) begin
          lo_d    = '1;
          hi_d    = a_q;
          state_d = S_DONE;
        end
`ifdef MD_EARLY_OUT_EN
        else if (!is_div && ((a_q == '0) || (b_q == '0))) begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = S_DONE;
        end
        else if (is_div && (a_q < b_q)) begin
          lo_d    = '0;
          hi_d    = a_q;
          state_d = S_DONE;
        end
`endif
        else begin
          hi_d    = '0;
          lo_d    = is_div ? a_q : b_q;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        bus.alu_req_o = 1'b1;
        if (is_div) begin
          bus.alu_sel_o = SelSub;
          bus.alu_a_o   = rs;
          bus.alu_b_o   = b_q;
        end else begin
          bus.alu_sel_o = SelAdd;
          bus.alu_a_o   = hi_q;
          bus.alu_b_o   = addend;
        end
        // A denied cycle leaves every register untouched.
        if (bus.alu_gnt_i) begin
          if (is_div) begin
            hi_d = take ? bus.alu_res_i : rs;
            lo_d = {lo_q[Width-2:0], take};
          end else begin
            hi_d = {carry, bus.alu_res_i[Width-1:1]};
            lo_d = {bus.alu_res_i[0], lo_q[Width-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(Width - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_data_o  = sel_hi ? hi_q : lo_q;
        if (bus.resp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A flush beats every transition, including an IDLE accept.
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_alu_sequencer.sv
// Directed testbench for md_alu_sequencer. The bench models the shared ALU
// (add/sub) and the pipeline grant, and checks results and latencies
// against hand-computed values.
module tb_md_alu_sequencer;

  localparam int W = 32;
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  logic clk_i = 1'b0;
  logic rst_i;

  int checks   = 0;
  int failures = 0;

  md_alu_sequencer_if #(.Width(W)) bus ();

  md_alu_sequencer #(.Width(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU model: same-cycle add/sub.
  assign bus.alu_res_i = (bus.alu_sel_o == 4'b0001) ? (bus.alu_a_o - bus.alu_b_o)
                                                    : (bus.alu_a_o + bus.alu_b_o);

  // Reset-value vector: {resp_valid, alu_req, busy, req_ready, sel, data, a, b}
  localparam logic [103:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 96'h0};

  function automatic logic [103:0] out_vec();
    return {bus.resp_valid_o, bus.alu_req_o, bus.busy_o, bus.req_ready_o,
            bus.alu_sel_o, bus.resp_data_o, bus.alu_a_o, bus.alu_b_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one operation, run it to DONE, collect the result and consume it.
  // edges counts clock edges from the accepting edge to resp_valid_o.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit rand_gnt, output logic [W-1:0] data, output int edges,
                        output int req_cycles, output int denied, output int frozen_err);
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    bit           den;
    edges      = 0;
    req_cycles = 0;
    denied     = 0;
    frozen_err = 0;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    while (!bus.resp_valid_o && edges < 500) begin
      bus.alu_gnt_i = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      pa  = bus.alu_a_o;
      pb  = bus.alu_b_o;
      den = bus.alu_req_o && !bus.alu_gnt_i;
      if (bus.alu_req_o) req_cycles++;
      if (den) denied++;
      tick();
      edges++;
      if (den && bus.alu_req_o && (bus.alu_a_o !== pa || bus.alu_b_o !== pb)) frozen_err++;
    end
    data          = bus.resp_data_o;
    bus.alu_gnt_i = 1'b1;
    if (bus.resp_valid_o) begin
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [103:0] got;
    rst_i            = 1'b1;
    bus.flush_i      = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = 2'b00;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.resp_ready_i = 1'b0;
    bus.alu_gnt_i    = 1'b1;
    #12;
    got = out_vec();
    checks++;
    if (got !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", got, RESET_VEC);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    got = out_vec();
    checks++;
    if (got !== RESET_VEC) begin
      failures++;
      $display("FAIL idle_after_reset got=%h exp=%h", got, RESET_VEC);
    end
  endtask

  task automatic test_mul_basic();
    logic [W-1:0] d;
    int e, r, dn, fz;
    run_op(OP_MUL, 32'd7, 32'd6, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd42) begin failures++; $display("FAIL mul_7x6 got=%h exp=%h", d, 32'd42); end
    checks++;
    if (e != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", e); end
    checks++;
    if (r != 32) begin failures++; $display("FAIL mul_alu_req_cycles got=%0d exp=32", r); end
  endtask

  task automatic test_mul_max();
    logic [W-1:0] d;
    int e, r, dn, fz;
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'h0000_0001) begin failures++; $display("FAIL mul_max_lo got=%h exp=00000001", d); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_max got=%h exp=fffffffe", d); end
    run_op(OP_MULHU, 32'h8000_0000, 32'd6, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL mulhu_2p31x6 got=%h exp=00000003", d); end
  endtask

  task automatic test_div_random_grant();
    logic [W-1:0] d;
    int e, r, dn, fz;
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b1, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", d, 32'd14); end
    checks++;
    if (e != 33 + dn) begin failures++; $display("FAIL divu_latency got=%0d exp=%0d", e, 33 + dn); end
    checks++;
    if (fz != 0) begin failures++; $display("FAIL divu_frozen_on_deny got=%0d exp=0", fz); end
    run_op(OP_REMU, 32'd100, 32'd7, 1'b1, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=%h", d, 32'd2); end
    checks++;
    if (e != 33 + dn) begin failures++; $display("FAIL remu_latency got=%0d exp=%0d", e, 33 + dn); end
    checks++;
    if (r != 32 + dn) begin failures++; $display("FAIL remu_alu_req_cycles got=%0d exp=%0d", r, 32 + dn); end
    run_op(OP_MUL, 32'd1234, 32'd5678, 1'b1, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd7006652) begin failures++; $display("FAIL mul_rand_grant got=%0d exp=7006652", d); end
  endtask

  task automatic test_div_boundary();
    logic [W-1:0] d;
    int e, r, dn, fz;
    run_op(OP_DIVU, 32'h1234, 32'd0, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by_zero got=%h exp=ffffffff", d); end
    checks++;
    if (e != 1 || r != 0) begin failures++; $display("FAIL divu_by_zero_timing edges=%0d req=%0d exp=1/0", e, r); end
    run_op(OP_REMU, 32'h1234, 32'd0, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'h0000_1234) begin failures++; $display("FAIL remu_by_zero got=%h exp=00001234", d); end
    checks++;
    if (e != 1 || r != 0) begin failures++; $display("FAIL remu_by_zero_timing edges=%0d req=%0d exp=1/0", e, r); end
    run_op(OP_DIVU, 32'h8000_0000, 32'd1, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'h8000_0000) begin failures++; $display("FAIL divu_2p31_by_1 got=%h exp=80000000", d); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL remu_large_divisor got=%h exp=00000001", d); end
  endtask

  task automatic test_flush_mid_mul();
    logic [W-1:0] d;
    int e, r, dn, fz;
    int seen;
    logic [3:0] got;
    bus.req_op_i    = OP_MUL;
    bus.req_a_i     = 32'hDEAD_BEEF;
    bus.req_b_i     = 32'h0000_1234;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    got = {bus.resp_valid_o, bus.req_ready_o, bus.alu_req_o, bus.busy_o};
    checks++;
    if (got !== 4'b0100) begin failures++; $display("FAIL flush_iter_state got=%b exp=0100", got); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid_o) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_response got=%0d exp=0", seen); end
    run_op(OP_MUL, 32'd3, 32'd5, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd15 || e != 33) begin
      failures++;
      $display("FAIL mul_after_flush got=%0d/%0d exp=15/33", d, e);
    end
  endtask

  task automatic test_flush_done_and_idle();
    logic [2:0] got;
    bus.req_op_i    = OP_DIVU;
    bus.req_a_i     = 32'd9;
    bus.req_b_i     = 32'd0;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    checks++;
    if (bus.resp_valid_o !== 1'b1) begin failures++; $display("FAIL reach_done got=%b exp=1", bus.resp_valid_o); end
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    got = {bus.resp_valid_o, bus.busy_o, bus.req_ready_o};
    checks++;
    if (got !== 3'b001) begin failures++; $display("FAIL flush_in_done got=%b exp=001", got); end
    bus.req_valid_i = 1'b1;
    bus.flush_i     = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    got = {bus.resp_valid_o, bus.busy_o, bus.req_ready_o};
    checks++;
    if (got !== 3'b001) begin failures++; $display("FAIL flush_rejects_req got=%b exp=001", got); end
  endtask

  task automatic test_done_hold();
    int n;
    logic [2:0] got;
    bus.req_op_i    = OP_DIVU;
    bus.req_a_i     = 32'd100;
    bus.req_b_i     = 32'd7;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    n = 0;
    while (!bus.resp_valid_o && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 33) begin failures++; $display("FAIL hold_latency got=%0d exp=33", n); end
    // A request offered during DONE must be ignored.
    bus.req_op_i    = OP_MUL;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.resp_data_o !== 32'd14 || bus.req_ready_o !== 1'b0 || bus.resp_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL done_hold_%0d data=%h ready=%b valid=%b exp=0000000e/0/1",
                 i, bus.resp_data_o, bus.req_ready_o, bus.resp_valid_o);
      end
      tick();
    end
    bus.req_valid_i  = 1'b0;
    bus.resp_ready_i = 1'b1;
    tick();
    bus.resp_ready_i = 1'b0;
    got = {bus.resp_valid_o, bus.busy_o, bus.req_ready_o};
    checks++;
    if (got !== 3'b001) begin failures++; $display("FAIL done_release got=%b exp=001", got); end
  endtask

  task automatic test_reset_mid_iter();
    logic [103:0] got;
    bus.req_op_i    = OP_MUL;
    bus.req_a_i     = 32'd7;
    bus.req_b_i     = 32'd6;
    bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.alu_req_o !== 1'b1) begin failures++; $display("FAIL pre_reset_iter got=%b exp=1", bus.alu_req_o); end
    #2;
    rst_i = 1'b1;
    #1;
    got = out_vec();
    checks++;
    if (got !== RESET_VEC) begin failures++; $display("FAIL async_reset got=%h exp=%h", got, RESET_VEC); end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    got = out_vec();
    checks++;
    if (got !== RESET_VEC) begin failures++; $display("FAIL post_reset_idle got=%h exp=%h", got, RESET_VEC); end
  endtask

  task automatic test_early_out();
    logic [W-1:0] d;
    int e, r, dn, fz;
    int exp_e;
`ifdef MD_EARLY_OUT_EN
    exp_e = 1;
`else
    exp_e = 33;
`endif
    run_op(OP_DIVU, 32'd3, 32'd9, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd0 || e != exp_e) begin
      failures++;
      $display("FAIL divu_3_9 got=%h/%0d exp=00000000/%0d", d, e, exp_e);
    end
    run_op(OP_REMU, 32'd3, 32'd9, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd3 || e != exp_e) begin
      failures++;
      $display("FAIL remu_3_9 got=%h/%0d exp=00000003/%0d", d, e, exp_e);
    end
    run_op(OP_MULHU, 32'd0, 32'hFFFF_FFFF, 1'b0, d, e, r, dn, fz);
    checks++;
    if (d !== 32'd0 || e != exp_e) begin
      failures++;
      $display("FAIL mulhu_zero got=%h/%0d exp=00000000/%0d", d, e, exp_e);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div_random_grant();
    test_div_boundary();
    test_flush_mid_mul();
    test_flush_done_and_idle();
    test_done_hold();
    test_reset_mid_iter();
    test_early_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md_alu_sequencer.md
Name: md_alu_sequencer

Overview:
- Iterative unsigned multiply/divide controller for the EX stage. Runs MUL, MULHU, DIVU and REMU by issuing one ALU add/sub per step on the shared 32-bit ALU.
- The ALU port is shared with the main pipeline. The pipeline has priority, so a step proceeds only when the ALU is granted.
- Shift and iteration state are held locally. The ALU does only the 32-bit add/sub.

Parameters:
- Width, 32: operand/result width.
- CntW, $clog2(Width): iteration counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  abort in-flight operation (pipeline flush).
- req_valid_i  in  1  operation request.
- req_ready_o  out  1  sequencer can accept.
- req_op_i  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
- req_a_i  in  Width  multiplicand / dividend.
- req_b_i  in  Width  multiplier / divisor.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  consumer takes result.
- resp_data_o  out  Width  result.
- busy_o  out  1  state != IDLE.
- alu_req_o  out  1  request shared ALU this cycle.
- alu_gnt_i  in  1  ALU granted this cycle (combinational).
- alu_a_o  out  Width  ALU DataA.
- alu_b_o  out  Width  ALU DataB.
- alu_sel_o  out  4  ALU select: 0000 add, 0001 sub.
- alu_res_i  in  Width  ALU result (same cycle).

Behaviour:
- Reset (async, rst_i=1):
  - State IDLE; all registers 0.
  - resp_valid_o=0, alu_req_o=0, busy_o=0, resp_data_o=0, alu_a_o=alu_b_o=0, alu_sel_o=0000.
  - req_ready_o=1, since it is a decode of IDLE.
- States: IDLE -> CHECK -> ITER -> DONE -> IDLE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch op, a, b; clear counter; go to CHECK.
- CHECK (1 cycle, no ALU use):
  - DIVU/REMU with b==0: quotient=all ones, remainder=a; go to DONE.
  - Otherwise initialise the datapath and go to ITER.
    - MUL: acc=0, mplr=b, mcand=a.
    - DIV: rem=0, quo=a, dvsr=b.
- ITER:
  - alu_req_o=1 every cycle. A step commits at the clock edge only when alu_gnt_i=1; when alu_gnt_i=0, all state holds.
  - MUL/MULHU step:
    - Drive alu_sel_o=0000, alu_a_o=acc, alu_b_o = mplr[0] ? mcand : 0.
    - carry = (alu_res_i < acc).
    - {acc,mplr} <= {carry, alu_res_i, mplr} >> 1, keeping low 2*Width bits.
  - DIVU/REMU step:
    - t = rem[Width-1]; rs = {rem[Width-2:0], quo[Width-1]}.
    - Drive alu_sel_o=0001, alu_a_o=rs, alu_b_o=dvsr.
    - If t==1 or rs>=dvsr: rem<=alu_res_i, qbit=1. Else rem<=rs, qbit=0.
    - quo <= {quo[Width-2:0], qbit}.
  - Counter increments per committed step. After step Width-1 commits, go to DONE.
- DONE:
  - resp_valid_o=1.
  - resp_data_o: MUL=mplr (low product), MULHU=acc, DIVU=quo, REMU=rem.
  - Data is held stable while resp_ready_i=0. On resp_ready_i, go to IDLE.
  - No new request is accepted in DONE.
- Latency with continuous grant: resp_valid_o rises Width+1 edges after the accepting edge. Divide-by-zero: 1 edge. Each denied grant adds 1.
- flush_i has priority over all transitions:
  - Any state goes to IDLE at the next edge and no response is produced.
  - A flush in DONE drops the pending result.
  - A flush coinciding with req_valid_i in IDLE rejects the request (no accept).
- alu_req_o=0 outside ITER. The ALU operand outputs are don't-care when alu_req_o=0 but must not be X.
- Reset asserted mid-operation aborts immediately; there is no response.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: CHECK also finishes directly to DONE, with no ALU use, when:
  - MUL/MULHU with a==0 or b==0: result 0.
  - DIVU/REMU with a<b: quotient 0, remainder a.
  - Latency for these cases: 1 edge.
- Undefined: these cases run the full Width iterations and produce identical results.

Test Plan:
1. MUL a=7, b=6, alu_gnt_i=1 -> resp_data_o=42; resp_valid_o 33 edges after accept; alu_req_o high exactly 32 cycles.
2. MUL/MULHU a=b=0xFFFFFFFF -> MUL 0x00000001, MULHU 0xFFFFFFFE.
3. DIVU/REMU a=100, b=7, alu_gnt_i random 50% -> 14 / 2; latency = 33 + number of denied ITER cycles; state frozen on denied cycles.
4. DIVU/REMU a=0x1234, b=0 -> 0xFFFFFFFF / 0x00001234 after 1 edge; alu_req_o never asserted. Also DIVU 0x80000000/1 -> 0x80000000.
5. flush_i at step 10 of MUL -> no resp_valid_o; next cycle req_ready_o=1, alu_req_o=0; a following MUL 3*5 returns 15.
6. DONE with resp_ready_i low 5 cycles -> resp_data_o stable, req_ready_o=0. Then rst_i pulsed mid-ITER -> all outputs reach reset values asynchronously. With MD_EARLY_OUT_EN, DIVU 3/9 -> 0 after 1 edge.
